// File: rtl/prim_flop_en_wr_arb.sv
// Round-robin write scheduler sharing one enabled register among NumReq requesters.
// Latency: req sampled cycle 0, flop enable cycle 1, ack + new q_o cycle 2; requesters hold req until ack.
// Optional write lock (lock_i/err_o) is compiled in with `define PRIM_FLOP_ARB_LOCK_EN.

module prim_xilinx_flop_en #(
  parameter int                 Width      = 32,
  parameter logic [Width-1:0]   ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);
  logic [Width-1:0] q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= ResetValue;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;
endmodule

module prim_flop_en_wr_arb #(
  parameter int               NumReq     = 4,
  parameter int               Width      = 32,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumReq-1:0]       req_i,
  input  logic [NumReq*Width-1:0] data_i,
  output logic [NumReq-1:0]       gnt_o,
  output logic [NumReq-1:0]       ack_o,
  output logic                    busy_o,
`ifdef PRIM_FLOP_ARB_LOCK_EN
  input  logic                    lock_i,
  output logic [NumReq-1:0]       err_o,
`endif
  output logic [Width-1:0]        q_o
);
  localparam int IdxW = $clog2(NumReq);

  typedef enum logic [1:0] {StIdle, StWrite, StAck} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   ptr_q, ptr_d, win_q, win_idx;
  logic [NumReq-1:0] gnt_q, ack_q, win_oh;
  logic              busy_q, win_vld, lock_w, wr_en;
  logic [Width-1:0]  wr_dat;

`ifdef PRIM_FLOP_ARB_LOCK_EN
  logic [NumReq-1:0] err_q;
  assign lock_w = lock_i;
  assign err_o  = err_q;
`else
  assign lock_w = 1'b0;
`endif

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NumReq; k++) begin
      idx = (int'(ptr_q) + k) % NumReq;
      if (!win_vld && req_i[IdxW'(idx)]) begin
        win_vld = 1'b1;
        win_idx = IdxW'(idx);
      end
    end
  end

  always_comb begin
    win_oh = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (win_idx == IdxW'(i)) win_oh[i] = 1'b1;
    end
    ptr_d = (int'(win_idx) == NumReq - 1) ? '0 : win_idx + 1'b1;
  end

  always_comb begin
    wr_dat = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (win_q == IdxW'(i)) wr_dat = data_i[i*Width +: Width];
    end
  end

  assign wr_en = (state_q == StWrite) && !lock_w;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
`ifdef PRIM_FLOP_ARB_LOCK_EN
      err_q   <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (win_vld) begin
            state_q <= StWrite;
            win_q   <= win_idx;
            gnt_q   <= win_oh;
            busy_q  <= 1'b1;
            ptr_q   <= ptr_d;
          end
        end
        StWrite: begin
          state_q <= StAck;
          ack_q   <= gnt_q;
`ifdef PRIM_FLOP_ARB_LOCK_EN
          err_q   <= lock_i ? gnt_q : '0;
`endif
        end
        StAck: begin
          state_q <= StIdle;
          ack_q   <= '0;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
`ifdef PRIM_FLOP_ARB_LOCK_EN
          err_q   <= '0;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  prim_xilinx_flop_en #(
    .Width      (Width),
    .ResetValue (ResetValue)
  ) u_flop (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (wr_en),
    .d_i    (wr_dat),
    .q_o    (q_o)
  );

  assign gnt_o  = gnt_q;
  assign ack_o  = ack_q;
  assign busy_o = busy_q;
endmodule
